dense_4_engine: RTL and testbench

- Fully-connected (dense_4) compute stage; directly consumes the dense_4 weight ROM (8-bit words, 1-cycle registered read with `en`).
- Sequences ROM addresses and the matching activation-buffer addresses, and runs a signed MAC per output neuron.
- Requantizes each accumulator to int8 and streams NUM_OUT results, one per neuron, to the classifier/output register stage.

---
 rtl/dense_pkg.sv | 28 ++
 rtl/dense_requant.sv | 62 ++++++
 rtl/dense_4_engine.sv | 176 +++++++++++++++++
 tb/tb_dense_4_engine.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/dense_pkg.sv
// Shared constants, FSM state type and saturation helper for the dense layer engines.
package dense_pkg;

  localparam int DATA_W  = 8;
  localparam int ACC_W   = 32;
  localparam int OPND_W  = DATA_W + 1;
  localparam int PROD_W  = 2 * DATA_W + 1;
  localparam int QPROD_W = 64;
  localparam int QMULT_W = 31;

  localparam logic [QMULT_W-1:0] Q_MULT_DEF = 31'd2014687024;
  localparam int Q_SHIFT_DEF    = 38;
  localparam int OFFSET_ENT_DEF = 1;
  localparam int OFFSET_SOR_DEF = -1;

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, REQ, EMIT, DONE} state_t;

  function automatic logic signed [DATA_W-1:0] sat_int8(input logic signed [QPROD_W-1:0] v);
    if (v > 64'sd127) begin
      return 8'sd127;
    end else if (v < -64'sd128) begin
      return -8'sd128;
    end else begin
      return v[DATA_W-1:0];
    end
  endfunction

endpackage

// File: rtl/dense_requant.sv
// Two-stage requantizer: multiply, round-half-up shift, add output zero point, saturate to int8.
// Optional ReLU clamp at the output zero point when DENSE4_RELU_EN is defined.
module dense_requant
  import dense_pkg::*;
#(
  parameter logic [QMULT_W-1:0] Q_MULT     = Q_MULT_DEF,
  parameter int                 Q_SHIFT    = Q_SHIFT_DEF,
  parameter int                 OFFSET_SOR = OFFSET_SOR_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] out_data
);

  localparam logic signed [QPROD_W-1:0] ROUND = 64'sd1 <<< (Q_SHIFT - 1);
  localparam logic signed [QPROD_W-1:0] OFS   = QPROD_W'(OFFSET_SOR);
  localparam logic signed [DATA_W-1:0]  OFS8  = DATA_W'(OFFSET_SOR);

  logic signed [QPROD_W-1:0] acc_ext;
  logic signed [QPROD_W-1:0] mult_ext;
  logic signed [QPROD_W-1:0] t_reg;
  logic signed [QPROD_W-1:0] r;
  logic signed [QPROD_W-1:0] y;
  logic signed [DATA_W-1:0]  y_sat;
  logic signed [DATA_W-1:0]  y_fin;
  logic                      v1_reg;

  assign acc_ext  = {{(QPROD_W-ACC_W){acc[ACC_W-1]}}, acc};
  assign mult_ext = {{(QPROD_W-QMULT_W){1'b0}}, Q_MULT};

  always_comb begin
    r     = (t_reg + ROUND) >>> Q_SHIFT;
    y     = r + OFS;
    y_sat = sat_int8(y);
    y_fin = y_sat;
`ifdef DENSE4_RELU_EN
    if (y_sat < OFS8) begin
      y_fin = OFS8;
    end
`endif
  end

  // out_data only moves one cycle after a valid product, so it holds between results
  always_ff @(posedge clk) begin
    if (rst) begin
      t_reg    <= '0;
      v1_reg   <= 1'b0;
      out_data <= '0;
    end else begin
      v1_reg <= in_valid;
      if (in_valid) begin
        t_reg <= acc_ext * mult_ext;
      end
      if (v1_reg) begin
        out_data <= y_fin;
      end
    end
  end

endmodule

// File: rtl/dense_4_engine.sv
// dense_4 fully-connected stage: sequences weight/activation reads, runs a signed MAC per neuron,
// requantizes to int8 and streams one result per neuron. ReLU option: DENSE4_RELU_EN.
module dense_4_engine
  import dense_pkg::*;
#(
  parameter int                 NUM_IN     = 169,
  parameter int                 NUM_OUT    = 3,
  parameter int                 ADDR_W     = 10,
  parameter int                 ACT_ADDR_W = 8,
  parameter logic [QMULT_W-1:0] Q_MULT     = Q_MULT_DEF,
  parameter int                 Q_SHIFT    = Q_SHIFT_DEF,
  parameter int                 OFFSET_ENT = OFFSET_ENT_DEF,
  parameter int                 OFFSET_SOR = OFFSET_SOR_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     w_en,
  output logic [ADDR_W-1:0]        w_addr,
  input  logic [DATA_W-1:0]        w_data,
  output logic                     act_en,
  output logic [ACT_ADDR_W-1:0]    act_addr,
  input  logic [DATA_W-1:0]        act_data,
  output logic                     out_valid,
  output logic [1:0]               out_idx,
  output logic signed [DATA_W-1:0] out_data
);

  localparam logic [ACT_ADDR_W-1:0] LAST_I = ACT_ADDR_W'(NUM_IN - 1);
  localparam logic [1:0]            LAST_O = 2'(NUM_OUT - 1);
  localparam logic signed [OPND_W-1:0] ENT9 = OPND_W'(OFFSET_ENT);

  state_t                    state_reg;
  logic [1:0]                o_reg;
  logic [ACT_ADDR_W-1:0]     i_reg;
  logic [ADDR_W-1:0]         w_addr_reg;
  logic [1:0]                phase_reg;

  logic                      d_valid_reg;
  logic                      op_valid_reg;
  logic                      prod_valid_reg;
  logic signed [OPND_W-1:0]  op_a_reg;
  logic signed [OPND_W-1:0]  op_w_reg;
  logic signed [PROD_W-1:0]  prod_reg;
  logic signed [PROD_W-1:0]  prod_full;
  logic signed [ACC_W-1:0]   acc_reg;
  logic                      rq_valid;

  // Weights are laid out neuron-major, so the ROM address is one running counter across the pass
  assign w_addr   = w_addr_reg;
  assign act_addr = i_reg;
  assign rq_valid = (state_reg == REQ) && (phase_reg == 2'd0);

  assign prod_full = $signed({{(PROD_W-OPND_W){op_a_reg[OPND_W-1]}}, op_a_reg})
                   * $signed({{(PROD_W-OPND_W){op_w_reg[OPND_W-1]}}, op_w_reg});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      o_reg          <= '0;
      i_reg          <= '0;
      w_addr_reg     <= '0;
      phase_reg      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      w_en           <= 1'b0;
      act_en         <= 1'b0;
      out_valid      <= 1'b0;
      out_idx        <= '0;
      d_valid_reg    <= 1'b0;
      op_valid_reg   <= 1'b0;
      prod_valid_reg <= 1'b0;
      op_a_reg       <= '0;
      op_w_reg       <= '0;
      prod_reg       <= '0;
      acc_reg        <= '0;
    end else begin
      // MAC pipeline: read data -> operand regs -> product reg -> accumulate
      d_valid_reg    <= w_en;
      op_valid_reg   <= d_valid_reg;
      prod_valid_reg <= op_valid_reg;
      if (d_valid_reg) begin
        op_a_reg <= $signed({act_data[DATA_W-1], act_data}) - ENT9;
        op_w_reg <= $signed({w_data[DATA_W-1], w_data});
      end
      if (op_valid_reg) begin
        prod_reg <= prod_full;
      end
      if (prod_valid_reg) begin
        acc_reg <= acc_reg + {{(ACC_W-PROD_W){prod_reg[PROD_W-1]}}, prod_reg};
      end

      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg  <= ISSUE;
            busy       <= 1'b1;
            o_reg      <= '0;
            i_reg      <= '0;
            w_addr_reg <= '0;
            w_en       <= 1'b1;
            act_en     <= 1'b1;
            acc_reg    <= '0;
          end
        end
        ISSUE: begin
          if (i_reg == LAST_I) begin
            state_reg <= DRAIN;
            w_en      <= 1'b0;
            act_en    <= 1'b0;
            phase_reg <= '0;
          end else begin
            i_reg      <= i_reg + ACT_ADDR_W'(1);
            w_addr_reg <= w_addr_reg + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (phase_reg == 2'd2) begin
            state_reg <= REQ;
            phase_reg <= '0;
          end else begin
            phase_reg <= phase_reg + 2'd1;
          end
        end
        REQ: begin
          if (phase_reg == 2'd1) begin
            state_reg <= EMIT;
            out_valid <= 1'b1;
            out_idx   <= o_reg;
            phase_reg <= '0;
          end else begin
            phase_reg <= phase_reg + 2'd1;
          end
        end
        EMIT: begin
          out_valid <= 1'b0;
          if (o_reg == LAST_O) begin
            state_reg <= DONE;
            done      <= 1'b1;
            busy      <= 1'b0;
          end else begin
            state_reg  <= ISSUE;
            o_reg      <= o_reg + 2'd1;
            i_reg      <= '0;
            w_addr_reg <= w_addr_reg + ADDR_W'(1);
            w_en       <= 1'b1;
            act_en     <= 1'b1;
            acc_reg    <= '0;
          end
        end
        DONE: begin
          done      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  dense_requant #(
    .Q_MULT     (Q_MULT),
    .Q_SHIFT    (Q_SHIFT),
    .OFFSET_SOR (OFFSET_SOR)
  ) u_requant (
    .clk      (clk),
    .rst      (rst),
    .in_valid (rq_valid),
    .acc      (acc_reg),
    .out_data (out_data)
  );

endmodule

// File: tb/tb_dense_4_engine.sv
// Self-checking bench for dense_4_engine: directed and random weight/activation sets checked
// against an arithmetic model of the layer, plus timing, start-filtering and mid-pass reset.
module tb_dense_4_engine;

  localparam int NI = 169;
  localparam int NO = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              busy, done, w_en, act_en, out_valid;
  logic [9:0]        w_addr;
  logic [7:0]        act_addr;
  logic [7:0]        w_data = '0;
  logic [7:0]        act_data = '0;
  logic [1:0]        out_idx;
  logic signed [7:0] out_data;

  logic signed [7:0] rom [0:NI*NO-1];
  logic signed [7:0] act_mem [0:NI-1];

  int n_assert = 0;
  int n_fail   = 0;
  int last_out [0:NO-1];

  always #5 clk = ~clk;

  // Registered-read memories, one cycle of latency after the enable
  always @(posedge clk) begin
    if (w_en)   w_data   <= rom[w_addr];
    if (act_en) act_data <= act_mem[act_addr];
  end

  dense_4_engine dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .w_en      (w_en),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .act_en    (act_en),
    .act_addr  (act_addr),
    .act_data  (act_data),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_data  (out_data)
  );

  task automatic chk(input string tag, input longint obs, input longint expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic longint model_acc(input int o);
    longint s = 0;
    for (int i = 0; i < NI; i++) s += (longint'(act_mem[i]) - 1) * longint'(rom[o*NI + i]);
    return s;
  endfunction

  function automatic int requant_model(input longint acc);
    longint t, r, y;
    t = acc * 64'sd2014687024;
    r = (t + (64'sd1 <<< 37)) >>> 38;
    y = r - 1;
    if (y > 127)  y = 127;
    if (y < -128) y = -128;
`ifdef DENSE4_RELU_EN
    if (y < -1) y = -1;
`endif
    return int'(y);
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_w_en"}, w_en, 0);
    chk({tag, "_w_addr"}, w_addr, 0);
    chk({tag, "_act_en"}, act_en, 0);
    chk({tag, "_act_addr"}, act_addr, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_idx"}, out_idx, 0);
    chk({tag, "_out_data"}, out_data, 0);
  endtask

  task automatic run_pass(input string tag, input bit pulse_busy);
    int  expo [0:NO-1];
    int  cyc, nvalid, eo, ei;
    bit  seen_done;
    for (int o = 0; o < NO; o++) expo[o] = requant_model(model_acc(o));
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0; nvalid = 0; eo = 0; ei = 0; seen_done = 0;
    while (!seen_done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk({tag, "_busy_rise"}, busy, 1);
      if (pulse_busy) begin
        if (cyc == 100 || cyc == 300) start = 1'b1;
        else start = 1'b0;
      end
      if (w_en) begin
        chk({tag, "_w_addr"}, w_addr, eo*NI + ei);
        chk({tag, "_act_addr"}, act_addr, ei);
        chk({tag, "_act_en"}, act_en, 1);
        ei++;
        if (ei == NI) begin ei = 0; eo++; end
      end
      if (out_valid) begin
        chk({tag, "_out_idx"}, out_idx, nvalid);
        if (nvalid < NO) begin
          chk({tag, "_out_data"}, out_data, expo[nvalid]);
          last_out[nvalid] = int'(out_data);
          $display("%s: neuron %0d out_data %0d (model %0d) at cycle %0d",
                   tag, out_idx, out_data, expo[nvalid], cyc);
        end
        nvalid++;
      end
      if (done) begin
        seen_done = 1;
        chk({tag, "_done_cycle"}, cyc, NO*(NI+6)+1);
        chk({tag, "_busy_at_done"}, busy, 0);
        chk({tag, "_valid_count"}, nvalid, NO);
        chk({tag, "_issue_count"}, eo*NI + ei, NO*NI);
      end
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, seen_done, 1);
    // start during the DONE cycle must be ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_start_in_done_busy"}, busy, 0);
    chk({tag, "_start_in_done_w_en"}, w_en, 0);
    @(negedge clk);
    chk({tag, "_idle_after_busy"}, busy, 0);
  endtask

  initial begin
    int nv, nd;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    // All weights 1, activations 2
    for (int k = 0; k < NI*NO; k++) rom[k] = 8'sd1;
    for (int i = 0; i < NI; i++) act_mem[i] = 8'sd2;
    run_pass("ones", 1'b0);
    chk("ones_const", last_out[0], 0);

    // Max positive -> saturate high
    for (int k = 0; k < NI*NO; k++) rom[k] = 8'sd127;
    for (int i = 0; i < NI; i++) act_mem[i] = 8'sd127;
    run_pass("satpos", 1'b1);
    chk("satpos_const", last_out[2], 127);

    // Max negative weights -> saturate low
    for (int k = 0; k < NI*NO; k++) rom[k] = -8'sd128;
    run_pass("satneg", 1'b0);
    chk("satneg_const", last_out[2], -128);

    // Neuron 1 zero weights, activation ramp
    for (int k = 0; k < NI*NO; k++) rom[k] = (k >= NI && k < 2*NI) ? 8'sd0 : 8'sd1;
    for (int i = 0; i < NI; i++) act_mem[i] = 8'(i);
    run_pass("zero_n1", 1'b1);
    chk("zero_n1_const", last_out[1], -1);

    // acc = -6686 gives y = -50 before the optional ReLU
    for (int k = 0; k < NI*NO; k++) rom[k] = -8'sd1;
    for (int i = 0; i < NI; i++) act_mem[i] = (i < 95) ? 8'sd41 : 8'sd40;
    run_pass("relu", 1'b0);
`ifdef DENSE4_RELU_EN
    chk("relu_const", last_out[0], -1);
`else
    chk("relu_const", last_out[0], -50);
`endif

    // Random sets
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < NI*NO; k++) rom[k] = 8'($urandom_range(0, 15)) - 8'sd8;
      for (int i = 0; i < NI; i++) act_mem[i] = 8'($urandom_range(0, 255));
      run_pass($sformatf("rand%0d", p), 1'b0);
    end

    // Reset during neuron 1 issue aborts the pass
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (NI + 6 + 40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("abort");
    rst = 1'b0;
    nv = 0; nd = 0;
    repeat (700) begin
      @(negedge clk);
      if (out_valid) nv++;
      if (done) nd++;
    end
    chk("abort_no_valid", nv, 0);
    chk("abort_no_done", nd, 0);
    $display("abort: reset mid-pass, %0d valid %0d done afterwards", nv, nd);

    for (int k = 0; k < NI*NO; k++) rom[k] = 8'($urandom_range(0, 31)) - 8'sd16;
    for (int i = 0; i < NI; i++) act_mem[i] = 8'($urandom_range(0, 255));
    run_pass("after_abort", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
